dnn_train_sequencer: RTL
========================

Name: dnn_train_sequencer

Overview:
- Training-schedule controller for the DNN top level.
- Aligns to the network's block cycle (`cycle_index`) and walks the ideal-output/input memory address across `TC` training cases per epoch.
- Counts epochs and steps the learning-rate shift (`etapos0`) on a fixed epoch schedule.
- Gates feeding with start/pause/done control, replacing the free-running `sel_tc` counter.

Parameters:
- TC, 12544, training cases per epoch; `tc_addr` range 0..TC-1.
- EPOCHS, 10, epochs to run before done.
- CPC, 18, clocks per block cycle; `cycle_index` range 0..CPC-1.
- ETA_W, 4, width of `etapos`.
- ETA_INIT, 3, `etapos` value at start of training.
- ETA_MAX, 7, saturation ceiling for `etapos`.
- ETA_STEP_EPOCHS, 2, `etapos` increments by 1 after every ETA_STEP_EPOCHS completed epochs (0 = never step).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- start, input, 1, single-cycle request to begin or restart training.
- pause, input, 1, level; hold off advancing at the next block boundary.
- cycle_index, input, $clog2(CPC), block-cycle phase from the DNN.
- tc_addr, output, $clog2(TC), training-case address to the ideal-output/input memories.
- sel_network, output, $clog2(CPC-2), per-clock mux select within the block.
- etapos, output, ETA_W, learning-rate shift to the DNN `etapos0`.
- epoch, output, $clog2(EPOCHS+1), completed-epoch count.
- feed_valid, output, 1, high while the network is being fed real cases.
- case_done, output, 1, one-clock pulse at the end of each fed case.
- done, output, 1, training complete (level).

Behaviour:
- Block boundary definition: `bnd` = (cycle_index == CPC-1).
- Reset values: state IDLE, tc_addr 0, epoch 0, etapos ETA_INIT, feed_valid 0, case_done 0, done 0.
- sel_network:
  - Combinational: (cycle_index - 2) truncated to $clog2(CPC-2) bits.
  - Valid in all states.
- FSM states: IDLE, ALIGN, RUN, PAUSE, DONE.
  - IDLE: start -> ALIGN.
  - ALIGN: on `bnd` -> RUN, so the first fed case begins at cycle_index 0.
  - RUN: feed_valid=1. On `bnd`:
    - Pulse case_done for that clock.
    - Update counters (rules below).
    - If this was the final case of the final epoch -> DONE.
    - Else if pause=1 -> PAUSE.
    - Else stay in RUN.
  - PAUSE: feed_valid=0, counters frozen. On `bnd` with pause=0 -> RUN.
  - DONE: done=1, feed_valid=0, counters hold final values. start -> ALIGN with tc_addr=0, epoch=0, etapos=ETA_INIT, done cleared the same clock.
- Counter update on each case_done:
  - tc_addr = (tc_addr==TC-1) ? 0 : tc_addr+1.
  - On wrap: epoch+1.
  - On wrap, if ETA_STEP_EPOCHS!=0 and (epoch+1) mod ETA_STEP_EPOCHS==0: etapos = min(etapos+1, ETA_MAX).
  - The final case is tc_addr==TC-1 with epoch==EPOCHS-1. On that case epoch becomes EPOCHS and tc_addr wraps to 0.
- start handling:
  - Ignored in ALIGN, RUN and PAUSE.
  - start and `bnd` in the same clock in IDLE: go to ALIGN; do not skip ahead to RUN.
- pause handling:
  - Sampled only on `bnd` in RUN; a mid-block pause never truncates a case.
  - pause high on the final case: DONE takes priority.
- Outputs are registered except sel_network. case_done is high exactly on the `bnd` clock in RUN.
- reset in any state, mid-operation included, returns to reset values the next clock. A start asserted with reset is dropped.

Test Plan (TC=4, EPOCHS=3, CPC=6, ETA_INIT=3, ETA_MAX=4, ETA_STEP_EPOCHS=1 unless noted):
- Start alignment: start pulse at cycle_index=2 -> feed_valid rises on the clock after cycle_index=5; tc_addr=0 during the first fed block.
- Full run: run to completion -> tc_addr sequence 0,1,2,3,0,... and epoch 0->1->2->3.
  - etapos goes 3->4 after epoch 1 and stays 4 (saturated).
  - Exactly 12 case_done pulses, then done=1 and tc_addr=0.
- Pause: pause asserted mid-block during case 1 -> case 1 completes, tc_addr=2 frozen, feed_valid=0.
  - Release pause -> resumes at the next `bnd` with tc_addr=2.
  - Releasing pause before a `bnd` is reached yields no lost cases.
- Restart from DONE: in DONE, start -> done clears, epoch=0, etapos=3, tc_addr=0; feeding resumes after the next `bnd`.
- Reset mid-RUN: reset asserted at tc_addr=2, epoch=1 -> next clock all outputs at reset values. A start presented together with reset is ignored; state stays IDLE.
- Ignored start and no eta step: with ETA_STEP_EPOCHS=0, start pulses during RUN are ignored and etapos stays 3 through done.

Source files
------------

// File: rtl/dnn_train_sequencer.sv
// Training-schedule controller: aligns to the DNN block cycle, walks training-case
// addresses across epochs and steps the learning-rate shift on a fixed epoch schedule.
module dnn_train_sequencer #(
  parameter int TC              = 12544,
  parameter int EPOCHS          = 10,
  parameter int CPC             = 18,
  parameter int ETA_W           = 4,
  parameter int ETA_INIT        = 3,
  parameter int ETA_MAX         = 7,
  parameter int ETA_STEP_EPOCHS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        pause,
  input  logic [$clog2(CPC)-1:0]      cycle_index,
  output logic [$clog2(TC)-1:0]       tc_addr,
  output logic [$clog2(CPC-2)-1:0]    sel_network,
  output logic [ETA_W-1:0]            etapos,
  output logic [$clog2(EPOCHS+1)-1:0] epoch,
  output logic                        feed_valid,
  output logic                        case_done,
  output logic                        done
);
  localparam int CI_W     = $clog2(CPC);
  localparam int SEL_W    = $clog2(CPC-2);
  localparam int TC_W     = $clog2(TC);
  localparam int EP_W     = $clog2(EPOCHS+1);
  localparam int STEP_DIV = (ETA_STEP_EPOCHS == 0) ? 1 : ETA_STEP_EPOCHS;

  typedef enum logic [2:0] {IDLE, ALIGN, RUN, PAUSE, DONE} state_t;

  state_t           state_q;
  logic [TC_W-1:0]  tc_q, tc_d;
  logic [EP_W-1:0]  epoch_q, epoch_d;
  logic [ETA_W-1:0] eta_q, eta_d;
  logic             feed_q, case_done_q, done_q;
  logic             bnd, pre_bnd, wrap, last_case, eta_step;
  logic [CI_W-1:0]  sel_full;
  logic [31:0]      epoch_plus1;

  assign bnd         = (cycle_index == CI_W'(CPC-1));
  assign pre_bnd     = (cycle_index == CI_W'(CPC-2));
  assign sel_full    = cycle_index - CI_W'(2);
  assign sel_network = sel_full[SEL_W-1:0];
  assign epoch_plus1 = 32'(epoch_q) + 32'd1;
  assign eta_step    = (ETA_STEP_EPOCHS != 0) && ((epoch_plus1 % 32'(STEP_DIV)) == 32'd0);

  always_comb begin
    wrap      = (tc_q == TC_W'(TC-1));
    tc_d      = wrap ? '0 : tc_q + TC_W'(1);
    epoch_d   = wrap ? epoch_q + EP_W'(1) : epoch_q;
    eta_d     = (wrap && eta_step && (eta_q < ETA_W'(ETA_MAX))) ? eta_q + ETA_W'(1) : eta_q;
    last_case = wrap && (epoch_q == EP_W'(EPOCHS-1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tc_q        <= '0;
      epoch_q     <= '0;
      eta_q       <= ETA_W'(ETA_INIT);
      feed_q      <= 1'b0;
      case_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) state_q <= ALIGN;
        ALIGN: begin
          if (bnd) begin
            state_q <= RUN;
            feed_q  <= 1'b1;
          end
        end
        RUN: begin
          // Registered pulse: raised one clock early so it is high during the bnd clock
          case_done_q <= pre_bnd;
          if (bnd) begin
            tc_q    <= tc_d;
            epoch_q <= epoch_d;
            eta_q   <= eta_d;
            if (last_case) begin
              state_q <= DONE;
              feed_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (pause) begin
              state_q <= PAUSE;
              feed_q  <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (bnd && !pause) begin
            state_q <= RUN;
            feed_q  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_q <= ALIGN;
            tc_q    <= '0;
            epoch_q <= '0;
            eta_q   <= ETA_W'(ETA_INIT);
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tc_addr    = tc_q;
  assign epoch      = epoch_q;
  assign etapos     = eta_q;
  assign feed_valid = feed_q;
  assign case_done  = case_done_q;
  assign done       = done_q;
endmodule
